lsu_issue_queue: RTL and testbench

//  In-order issue queue for memory ops, directly upstream of the LSU datapath.

---
 rtl/lsu_pkg.sv | 41 ++++
 rtl/lsu_iq_wakeup.sv | 24 ++
 rtl/lsu_issue_queue.sv | 164 ++++++++++++++++
 tb/tb_lsu_issue_queue.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types for the LSU issue queue: queue entry and issue bundle.
// Struct widths are fixed here and must match the module parameters.
package lsu_pkg;

    localparam int LSU_DATA_W = 32;
    localparam int LSU_ROB_W  = 4;
    localparam int LSU_PREG_W = 7;
    localparam int LSU_DEPTH  = 8;

    typedef struct packed {
        logic                  valid;
        logic                  memwrite;
        logic                  rs1_rdy;
        logic [LSU_PREG_W-1:0] prs1;
        logic [LSU_DATA_W-1:0] rs1_data;
        logic                  rs2_rdy;
        logic [LSU_PREG_W-1:0] prs2;
        logic [LSU_DATA_W-1:0] rs2_data;
        logic [LSU_DATA_W-1:0] imm;
        logic [LSU_PREG_W-1:0] prd;
        logic [LSU_ROB_W-1:0]  rob_tag;
    } lsu_iq_entry_t;

    typedef struct packed {
        logic                  valid;
        logic                  memwrite;
        logic [LSU_DATA_W-1:0] base_addr;
        logic [LSU_DATA_W-1:0] offset;
        logic [LSU_DATA_W-1:0] store_data;
        logic [LSU_PREG_W-1:0] prd;
        logic [LSU_ROB_W-1:0]  rob_tag;
    } lsu_issue_t;

    // Stores must additionally be at ROB head so memory is never written speculatively.
    function automatic logic entry_eligible(input lsu_iq_entry_t e,
                                            input logic [LSU_ROB_W-1:0] head_tag);
        return e.valid & e.rs1_rdy &
               (~e.memwrite | (e.rs2_rdy & (e.rob_tag == head_tag)));
    endfunction

endpackage

// File: rtl/lsu_iq_wakeup.sv
// Per-operand CDB tag compare: captures the broadcast value into a waiting operand.
module lsu_iq_wakeup #(
    parameter int DATA_WIDTH = 32,
    parameter int PREG_WIDTH = 7
) (
    input  logic                  i_valid,
    input  logic                  i_rdy,
    input  logic [PREG_WIDTH-1:0] i_tag,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_cdb_valid,
    input  logic [PREG_WIDTH-1:0] i_cdb_prd,
    input  logic [DATA_WIDTH-1:0] i_cdb_data,
    output logic                  o_rdy,
    output logic [DATA_WIDTH-1:0] o_data
);

    logic hit;

    // An operand that is already ready keeps its value even if the tag reappears.
    assign hit    = i_valid & ~i_rdy & i_cdb_valid & (i_cdb_prd == i_tag);
    assign o_rdy  = i_rdy | hit;
    assign o_data = hit ? i_cdb_data : i_data;

endmodule

// File: rtl/lsu_issue_queue.sv
// In-order memory-op issue queue: captures operands from the CDB and issues the
// oldest op to the LSU once ready (stores only at ROB head).
module lsu_issue_queue
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = LSU_DATA_W,
    parameter int ROB_WIDTH  = LSU_ROB_W,
    parameter int PREG_WIDTH = LSU_PREG_W,
    parameter int DEPTH      = LSU_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_disp_valid,
    output logic                  o_disp_ready,
    input  logic                  i_disp_memwrite,
    input  logic                  i_disp_rs1_rdy,
    input  logic [PREG_WIDTH-1:0] i_disp_prs1,
    input  logic [DATA_WIDTH-1:0] i_disp_rs1_data,
    input  logic                  i_disp_rs2_rdy,
    input  logic [PREG_WIDTH-1:0] i_disp_prs2,
    input  logic [DATA_WIDTH-1:0] i_disp_rs2_data,
    input  logic [DATA_WIDTH-1:0] i_disp_imm,
    input  logic [PREG_WIDTH-1:0] i_disp_prd,
    input  logic [ROB_WIDTH-1:0]  i_disp_rob_tag,
    input  logic                  i_cdb_valid,
    input  logic [PREG_WIDTH-1:0] i_cdb_prd,
    input  logic [DATA_WIDTH-1:0] i_cdb_data,
    input  logic [ROB_WIDTH-1:0]  i_rob_head_tag,
    input  logic                  i_flush,
    output logic                  o_valid,
    output logic                  o_memwrite,
    output logic [DATA_WIDTH-1:0] o_base_addr,
    output logic [DATA_WIDTH-1:0] o_offset,
    output logic [DATA_WIDTH-1:0] o_store_data,
    output logic [PREG_WIDTH-1:0] o_prd,
    output logic [ROB_WIDTH-1:0]  o_rob_tag
);

    localparam int              PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0]  FULL_CNT = (PTR_W+1)'(DEPTH);

    lsu_iq_entry_t    entries_q [DEPTH];
    lsu_iq_entry_t    entries_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;
    lsu_issue_t       issue_q, issue_d;

    logic [DEPTH-1:0]      rs1_rdy_w, rs2_rdy_w;
    logic [DATA_WIDTH-1:0] rs1_data_w [DEPTH];
    logic [DATA_WIDTH-1:0] rs2_data_w [DEPTH];
    logic                  byp_rs1_rdy, byp_rs2_rdy;
    logic [DATA_WIDTH-1:0] byp_rs1_data, byp_rs2_data;

    lsu_iq_entry_t head_ent;
    logic          do_pop, do_push;

    for (genvar g = 0; g < DEPTH; g++) begin : g_wake
        lsu_iq_wakeup #(.DATA_WIDTH(DATA_WIDTH), .PREG_WIDTH(PREG_WIDTH)) u_rs1 (
            .i_valid(entries_q[g].valid), .i_rdy(entries_q[g].rs1_rdy),
            .i_tag(entries_q[g].prs1), .i_data(entries_q[g].rs1_data),
            .i_cdb_valid(i_cdb_valid), .i_cdb_prd(i_cdb_prd), .i_cdb_data(i_cdb_data),
            .o_rdy(rs1_rdy_w[g]), .o_data(rs1_data_w[g]));
        lsu_iq_wakeup #(.DATA_WIDTH(DATA_WIDTH), .PREG_WIDTH(PREG_WIDTH)) u_rs2 (
            .i_valid(entries_q[g].valid), .i_rdy(entries_q[g].rs2_rdy),
            .i_tag(entries_q[g].prs2), .i_data(entries_q[g].rs2_data),
            .i_cdb_valid(i_cdb_valid), .i_cdb_prd(i_cdb_prd), .i_cdb_data(i_cdb_data),
            .o_rdy(rs2_rdy_w[g]), .o_data(rs2_data_w[g]));
    end

    // Dispatch bypass: a broadcast in the dispatch cycle lands in the new entry.
    lsu_iq_wakeup #(.DATA_WIDTH(DATA_WIDTH), .PREG_WIDTH(PREG_WIDTH)) u_byp_rs1 (
        .i_valid(i_disp_valid), .i_rdy(i_disp_rs1_rdy),
        .i_tag(i_disp_prs1), .i_data(i_disp_rs1_data),
        .i_cdb_valid(i_cdb_valid), .i_cdb_prd(i_cdb_prd), .i_cdb_data(i_cdb_data),
        .o_rdy(byp_rs1_rdy), .o_data(byp_rs1_data));
    lsu_iq_wakeup #(.DATA_WIDTH(DATA_WIDTH), .PREG_WIDTH(PREG_WIDTH)) u_byp_rs2 (
        .i_valid(i_disp_valid), .i_rdy(i_disp_rs2_rdy),
        .i_tag(i_disp_prs2), .i_data(i_disp_rs2_data),
        .i_cdb_valid(i_cdb_valid), .i_cdb_prd(i_cdb_prd), .i_cdb_data(i_cdb_data),
        .o_rdy(byp_rs2_rdy), .o_data(byp_rs2_data));

    assign o_disp_ready = (count_q != FULL_CNT);
    assign head_ent     = entries_q[head_q];
    // Eligibility uses registered readiness, so a wakeup is usable the cycle after.
    assign do_pop       = entry_eligible(head_ent, i_rob_head_tag);
    assign do_push      = i_disp_valid & o_disp_ready;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entries_d[i]          = entries_q[i];
            entries_d[i].rs1_rdy  = rs1_rdy_w[i];
            entries_d[i].rs1_data = rs1_data_w[i];
            entries_d[i].rs2_rdy  = rs2_rdy_w[i];
            entries_d[i].rs2_data = rs2_data_w[i];
        end
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        issue_d = '0;

        if (do_pop) begin
            entries_d[head_q].valid = 1'b0;
            head_d                  = head_q + 1'b1;
            issue_d.valid           = 1'b1;
            issue_d.memwrite        = head_ent.memwrite;
            issue_d.base_addr       = head_ent.rs1_data;
            issue_d.offset          = head_ent.imm;
            issue_d.store_data      = head_ent.rs2_data;
            issue_d.prd             = head_ent.prd;
            issue_d.rob_tag         = head_ent.rob_tag;
        end

        // Push never targets the popped slot: tail==head only when empty or full.
        if (do_push) begin
            entries_d[tail_q].valid    = 1'b1;
            entries_d[tail_q].memwrite = i_disp_memwrite;
            entries_d[tail_q].rs1_rdy  = byp_rs1_rdy;
            entries_d[tail_q].prs1     = i_disp_prs1;
            entries_d[tail_q].rs1_data = byp_rs1_data;
            entries_d[tail_q].rs2_rdy  = byp_rs2_rdy;
            entries_d[tail_q].prs2     = i_disp_prs2;
            entries_d[tail_q].rs2_data = byp_rs2_data;
            entries_d[tail_q].imm      = i_disp_imm;
            entries_d[tail_q].prd      = i_disp_prd;
            entries_d[tail_q].rob_tag  = i_disp_rob_tag;
            tail_d                     = tail_q + 1'b1;
        end

        count_d = count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);

        if (i_flush) begin
            for (int i = 0; i < DEPTH; i++) entries_d[i].valid = 1'b0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            issue_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            issue_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) entries_q[i] <= entries_d[i];
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            issue_q <= issue_d;
        end
    end

    assign o_valid      = issue_q.valid;
    assign o_memwrite   = issue_q.memwrite;
    assign o_base_addr  = issue_q.base_addr;
    assign o_offset     = issue_q.offset;
    assign o_store_data = issue_q.store_data;
    assign o_prd        = issue_q.prd;
    assign o_rob_tag    = issue_q.rob_tag;

endmodule

// File: tb/tb_lsu_issue_queue.sv
// Bench for lsu_issue_queue: directed scenarios plus random traffic checked
// every cycle against an op-queue reference model.
module tb_lsu_issue_queue;

    localparam int DEPTH = 8;

    logic        clk = 0;
    logic        reset = 1;
    logic        disp_valid = 0, disp_memwrite = 0, rs1_rdy = 0, rs2_rdy = 0;
    logic [6:0]  prs1 = 0, prs2 = 0, prd = 0, cdb_prd = 0;
    logic [31:0] rs1_data = 0, rs2_data = 0, imm = 0, cdb_data = 0;
    logic [3:0]  rob_tag = 0, head_tag = 0;
    logic        cdb_valid = 0, flush = 0;

    logic        o_disp_ready, o_valid, o_memwrite;
    logic [31:0] o_base_addr, o_offset, o_store_data;
    logic [6:0]  o_prd;
    logic [3:0]  o_rob_tag;

    lsu_issue_queue dut (
        .clk(clk), .reset(reset),
        .i_disp_valid(disp_valid), .o_disp_ready(o_disp_ready),
        .i_disp_memwrite(disp_memwrite),
        .i_disp_rs1_rdy(rs1_rdy), .i_disp_prs1(prs1), .i_disp_rs1_data(rs1_data),
        .i_disp_rs2_rdy(rs2_rdy), .i_disp_prs2(prs2), .i_disp_rs2_data(rs2_data),
        .i_disp_imm(imm), .i_disp_prd(prd), .i_disp_rob_tag(rob_tag),
        .i_cdb_valid(cdb_valid), .i_cdb_prd(cdb_prd), .i_cdb_data(cdb_data),
        .i_rob_head_tag(head_tag), .i_flush(flush),
        .o_valid(o_valid), .o_memwrite(o_memwrite), .o_base_addr(o_base_addr),
        .o_offset(o_offset), .o_store_data(o_store_data), .o_prd(o_prd),
        .o_rob_tag(o_rob_tag));

    always #5 clk = ~clk;

    typedef struct {
        bit        mw;
        bit        r1;
        bit [6:0]  p1;
        bit [31:0] d1;
        bit        r2;
        bit [6:0]  p2;
        bit [31:0] d2;
        bit [31:0] imm;
        bit [6:0]  prd;
        bit [3:0]  rob;
    } mop_t;

    mop_t mq[$];
    int   n_chk = 0, n_err = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_op(input bit mw, input bit r1, input bit [6:0] p1, input bit [31:0] d1,
                          input bit r2, input bit [6:0] p2, input bit [31:0] d2,
                          input bit [31:0] im, input bit [6:0] pd, input bit [3:0] rob);
        disp_valid = 1; disp_memwrite = mw;
        rs1_rdy = r1; prs1 = p1; rs1_data = d1;
        rs2_rdy = r2; prs2 = p2; rs2_data = d2;
        imm = im; prd = pd; rob_tag = rob;
    endtask

    task automatic set_cdb(input bit [6:0] tag, input bit [31:0] data);
        cdb_valid = 1; cdb_prd = tag; cdb_data = data;
    endtask

    // One clock: model consumes this cycle's inputs, DUT outputs checked after the edge.
    task automatic step();
        mop_t h, n;
        bit   elig = 0;
        bit   acc;
        check("disp_ready", o_disp_ready, mq.size() < DEPTH);
        acc = disp_valid && (mq.size() < DEPTH);
        if (reset || flush) mq.delete();
        else begin
            if (mq.size() > 0) begin
                h = mq[0];
                elig = h.r1 && (!h.mw || (h.r2 && h.rob == head_tag));
            end
            foreach (mq[i]) begin
                if (cdb_valid && !mq[i].r1 && mq[i].p1 == cdb_prd) begin
                    mq[i].r1 = 1; mq[i].d1 = cdb_data;
                end
                if (cdb_valid && !mq[i].r2 && mq[i].p2 == cdb_prd) begin
                    mq[i].r2 = 1; mq[i].d2 = cdb_data;
                end
            end
            if (elig) void'(mq.pop_front());
            if (acc) begin
                n.mw = disp_memwrite; n.p1 = prs1; n.p2 = prs2;
                n.imm = imm; n.prd = prd; n.rob = rob_tag;
                n.r1 = rs1_rdy || (cdb_valid && cdb_prd == prs1);
                n.d1 = rs1_rdy ? rs1_data : cdb_data;
                n.r2 = rs2_rdy || (cdb_valid && cdb_prd == prs2);
                n.d2 = rs2_rdy ? rs2_data : cdb_data;
                mq.push_back(n);
            end
        end
        @(posedge clk); #1;
        check("o_valid", o_valid, elig);
        if (elig) begin
            check("issue", {o_memwrite, o_base_addr, o_offset, o_prd, o_rob_tag},
                  {h.mw, h.d1, h.imm, h.prd, h.rob});
            if (h.mw) check("store_data", o_store_data, h.d2);
        end
        disp_valid = 0; cdb_valid = 0; flush = 0; reset = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 0;
        check("rst_ready", o_disp_ready, 1'b1);
        check("rst_out", {o_valid, o_memwrite, o_base_addr, o_offset, o_store_data, o_prd, o_rob_tag}, '0);

        // Load fully ready issues two cycles after dispatch
        set_op(0, 1, 1, 32'h100, 0, 2, 0, 32'h8, 7'd9, 4'd3);
        step();
        check("t1_early", o_valid, 1'b0);
        step();
        check("t1_base", {o_valid, o_memwrite, o_base_addr, o_offset}, {1'b1, 1'b0, 32'h100, 32'h8});
        idle(1);

        // Load waits for base operand from CDB
        set_op(0, 0, 12, 0, 0, 3, 0, 32'h4, 7'd5, 4'd1);
        idle(3);
        set_cdb(12, 32'h40);
        step();
        check("t2_wait", o_valid, 1'b0);
        step();
        check("t2_base", {o_valid, o_base_addr}, {1'b1, 32'h40});
        idle(1);

        // Store not at ROB head blocks a younger ready load
        head_tag = 4;
        set_op(1, 1, 1, 32'h200, 1, 2, 32'hdead, 32'h0, 7'd0, 4'd5);
        step();
        set_op(0, 1, 3, 32'h300, 0, 4, 0, 32'h10, 7'd6, 4'd6);
        idle(4);
        check("t3_held", o_valid, 1'b0);
        head_tag = 5;
        step();
        check("t3_store", {o_valid, o_memwrite, o_store_data}, {1'b1, 1'b1, 32'hdead});
        step();
        check("t3_load", {o_valid, o_memwrite, o_base_addr}, {1'b1, 1'b0, 32'h300});
        idle(1);

        // Fill to full behind a blocked store
        head_tag = 0;
        set_op(1, 1, 1, 32'h500, 1, 2, 32'h55, 0, 0, 4'd5);
        step();
        for (int i = 1; i < DEPTH; i++) begin
            set_op(0, 1, 7'(i), 32'(i), 0, 0, 0, 0, 7'(i), 4'(i));
            step();
        end
        check("t4_full", o_disp_ready, 1'b0);
        set_op(0, 1, 9, 32'h999, 0, 0, 0, 0, 9, 9);
        step();
        head_tag = 5;
        step();
        check("t4_ready", o_disp_ready, 1'b1);
        idle(DEPTH + 2);

        // CDB bypass in dispatch cycle
        set_op(0, 0, 20, 0, 0, 0, 0, 32'h4, 7'd2, 4'd2);
        set_cdb(20, 32'h55);
        step();
        step();
        check("t5_bypass", {o_valid, o_base_addr}, {1'b1, 32'h55});
        idle(1);

        // Flush discards queued ops and the same-cycle dispatch
        head_tag = 0;
        set_op(1, 1, 1, 32'h1, 1, 1, 1, 0, 0, 4'd7);
        step();
        for (int i = 0; i < 3; i++) begin
            set_op(0, 1, 1, 32'h2, 0, 0, 0, 0, 0, 4'd8);
            step();
        end
        set_op(0, 1, 1, 32'h3, 0, 0, 0, 0, 0, 4'd9);
        flush = 1;
        step();
        check("t6_flush", {o_valid, o_disp_ready}, {1'b0, 1'b1});
        head_tag = 7;
        idle(4);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(99) < 60)
                set_op($urandom_range(1), $urandom_range(1), 7'($urandom_range(7)), $urandom,
                       $urandom_range(1), 7'($urandom_range(7)), $urandom, $urandom,
                       7'($urandom_range(127)), 4'($urandom_range(3)));
            if ($urandom_range(99) < 40) set_cdb(7'($urandom_range(7)), $urandom);
            if ($urandom_range(99) < 20) head_tag = 4'($urandom_range(3));
            if ($urandom_range(99) < 2) flush = 1;
            if ($urandom_range(199) < 1) reset = 1;
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
